// File: rtl/riscv_trap_ctrl_if.sv
// rtl/riscv_trap_ctrl_if.sv - commit-point, CSR and PC-select signal bundle for riscv_trap_ctrl
interface riscv_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            instr_valid_i;
  logic [31:0]     instr_i;
  logic            illegal_i;
  logic [XLEN-1:0] pc_i;
  logic [1:0]      core_pc_sel_i;
  logic            mem_busy_i;
  logic            irq_i;
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [1:0]      pc_sel_o;
  logic            kill_o;
  logic            flush_o;
  logic            stall_o;
  logic [XLEN-1:0] mepc_o;
  logic [XLEN-1:0] mcause_o;
  logic            mie_o;
  logic            mpie_o;

  // Core side: drives the commit point and observes trap control
  modport master (
    output instr_valid_i, instr_i, illegal_i, pc_i, core_pc_sel_i, mem_busy_i,
    output irq_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  pc_sel_o, kill_o, flush_o, stall_o, mepc_o, mcause_o, mie_o, mpie_o
  );

  // Trap controller side
  modport slave (
    input  instr_valid_i, instr_i, illegal_i, pc_i, core_pc_sel_i, mem_busy_i,
    input  irq_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output pc_sel_o, kill_o, flush_o, stall_o, mepc_o, mcause_o, mie_o, mpie_o
  );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// rtl/riscv_trap_ctrl.sv - trap/MRET sequencer and machine trap CSRs; RISCV_TRAP_IRQ_EN enables interrupt traps
module riscv_trap_ctrl #(
  parameter int XLEN = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  riscv_trap_ctrl_if.slave bus
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;
  localparam logic [1:0] S_RET   = 2'd3;

  localparam logic [1:0] PCS_NPC   = 2'd0;
  localparam logic [1:0] PCS_MEPC  = 2'd2;
  localparam logic [1:0] PCS_MTVEC = 2'd3;

  logic [1:0]      state;
  logic            pend_ret;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic            mie;
  logic            mpie;

  logic            is_sys;
  logic [11:0]     imm;
  logic            is_ecall;
  logic            is_ebreak;
  logic            is_mret;
  logic            irq_pend;
  logic            take_ok;
  logic            trap_take;
  logic            ret_take;
  logic [XLEN-1:0] cause;

  assign is_sys    = (bus.instr_i[6:2] == 5'b11100) && (bus.instr_i[14:12] == 3'b000);
  assign imm       = bus.instr_i[31:20];
  assign is_ecall  = is_sys && (imm == 12'h000);
  assign is_ebreak = is_sys && (imm == 12'h001);
  assign is_mret   = is_sys && (imm == 12'h302);

`ifdef RISCV_TRAP_IRQ_EN
  assign irq_pend = bus.irq_i & mie;
  logic unused_bits;
  assign unused_bits = ^{bus.instr_i[19:15], bus.instr_i[11:7], bus.instr_i[1:0], bus.pc_i[1:0]};
`else
  // Interrupts never trap and never pre-empt MRET in this build
  assign irq_pend = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.irq_i, bus.instr_i[19:15], bus.instr_i[11:7], bus.instr_i[1:0], bus.pc_i[1:0]};
`endif

  assign take_ok   = (state == S_RUN) && bus.instr_valid_i;
  assign trap_take = take_ok && (bus.illegal_i || is_ebreak || is_ecall || irq_pend);
  assign ret_take  = take_ok && !bus.illegal_i && !irq_pend && is_mret;

  // Cause selection in priority order: illegal, EBREAK, ECALL, interrupt
  always_comb begin
    cause = '0;
    if (bus.illegal_i)  cause = XLEN'(2);
    else if (is_ebreak) cause = XLEN'(3);
    else if (is_ecall)  cause = XLEN'(11);
    else                cause = {1'b1, (XLEN-1)'(11)};
  end

  // Sequencer state plus machine trap CSRs; CSR writes only land in RUN when nothing is killed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RUN;
      pend_ret <= 1'b0;
      mepc     <= '0;
      mcause   <= '0;
      mie      <= 1'b0;
      mpie     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (trap_take) begin
            mepc     <= {bus.pc_i[XLEN-1:2], 2'b00};
            mcause   <= cause;
            pend_ret <= 1'b0;
            state    <= bus.mem_busy_i ? S_DRAIN : S_TRAP;
          end else if (ret_take) begin
            pend_ret <= 1'b1;
            state    <= bus.mem_busy_i ? S_DRAIN : S_RET;
          end else if (bus.csr_we_i) begin
            case (bus.csr_addr_i)
              12'h300: begin
                mie  <= bus.csr_wdata_i[3];
                mpie <= bus.csr_wdata_i[7];
              end
              12'h341: mepc   <= {bus.csr_wdata_i[XLEN-1:2], 2'b00};
              12'h342: mcause <= bus.csr_wdata_i;
              default: ;
            endcase
          end
        end
        S_DRAIN: begin
          if (!bus.mem_busy_i) state <= pend_ret ? S_RET : S_TRAP;
        end
        S_TRAP: begin
          mpie  <= mie;
          mie   <= 1'b0;
          state <= S_RUN;
        end
        default: begin
          mie   <= mpie;
          mpie  <= 1'b1;
          state <= S_RUN;
        end
      endcase
    end
  end

  // Front-end control decoded from the sequencer state
  always_comb begin
    bus.pc_sel_o = bus.core_pc_sel_i;
    bus.flush_o  = 1'b0;
    bus.stall_o  = 1'b0;
    case (state)
      S_DRAIN: begin
        bus.pc_sel_o = PCS_NPC;
        bus.stall_o  = 1'b1;
      end
      S_TRAP: begin
        bus.pc_sel_o = PCS_MTVEC;
        bus.flush_o  = 1'b1;
        bus.stall_o  = 1'b1;
      end
      S_RET: begin
        bus.pc_sel_o = PCS_MEPC;
        bus.flush_o  = 1'b1;
        bus.stall_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.kill_o   = trap_take || ret_take;
  assign bus.mepc_o   = mepc;
  assign bus.mcause_o = mcause;
  assign bus.mie_o    = mie;
  assign bus.mpie_o   = mpie;
endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// tb/tb_riscv_trap_ctrl.sv - directed and randomized checks of riscv_trap_ctrl against a transaction-level model
module tb_riscv_trap_ctrl;
  localparam int XLEN = 32;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
`ifdef RISCV_TRAP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_trap_ctrl_if #(.XLEN(XLEN)) bus ();
  riscv_trap_ctrl #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic        m_mie;
  logic        m_mpie;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ill, input logic [31:0] pc,
                       input logic [1:0] cs, input logic busy, input logic irq, input logic we,
                       input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.instr_valid_i = v;
    bus.instr_i       = ins;
    bus.illegal_i     = ill;
    bus.pc_i          = pc;
    bus.core_pc_sel_i = cs;
    bus.mem_busy_i    = busy;
    bus.irq_i         = irq;
    bus.csr_we_i      = we;
    bus.csr_addr_i    = a;
    bus.csr_wdata_i   = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, I_NOP, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick_instr(input int k);
    case (k)
      0:       return I_ECALL;
      1:       return I_EBREAK;
      2:       return I_MRET;
      3:       return I_NOP;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [11:0] pick_addr(input int k);
    case (k)
      0:       return 12'h300;
      1:       return 12'h341;
      2:       return 12'h342;
      default: return 12'h305;
    endcase
  endfunction

  // Anything offered outside RUN must be ignored by the DUT
  task automatic drive_junk(input logic busy);
    drive(1'($urandom), pick_instr($urandom_range(0, 4)), 1'($urandom), $urandom,
          2'($urandom_range(0, 1)), busy, 1'($urandom), 1'($urandom),
          pick_addr($urandom_range(0, 3)), $urandom);
  endtask

  task automatic chk_csr(input string tag);
    chk({tag, "_mepc"},   bus.mepc_o,        m_mepc);
    chk({tag, "_mcause"}, bus.mcause_o,      m_mcause);
    chk({tag, "_mie"},    32'(bus.mie_o),    32'(m_mie));
    chk({tag, "_mpie"},   32'(bus.mpie_o),   32'(m_mpie));
  endtask

  task automatic model_reset();
    m_mepc = 32'h0; m_mcause = 32'h0; m_mie = 1'b0; m_mpie = 1'b0;
  endtask

  // One instruction at the commit point: nb = cycles mem_busy_i is high starting at T
  task automatic do_txn(input logic [31:0] ins, input logic ill, input logic [31:0] pc, input logic [1:0] cs,
                        input int nb, input logic irq, input logic we, input logic [11:0] a,
                        input logic [31:0] wd);
    logic        sys;
    logic [11:0] imm;
    int          kind;
    logic [31:0] cause;
    sys   = (ins[6:2] == 5'b11100) && (ins[14:12] == 3'b000);
    imm   = ins[31:20];
    kind  = 0;
    cause = 32'h0;
    if (ill)                             begin kind = 1; cause = 32'd2;        end
    else if (sys && imm == 12'h001)      begin kind = 1; cause = 32'd3;        end
    else if (sys && imm == 12'h000)      begin kind = 1; cause = 32'd11;       end
    else if (IRQ_ON && irq && m_mie)     begin kind = 1; cause = 32'h8000_000B; end
    else if (sys && imm == 12'h302)      begin kind = 2;                       end

    drive(1'b1, ins, ill, pc, cs, nb > 0, irq, we, a, wd);
    chk("t_kill",   32'(bus.kill_o),   32'(kind != 0));
    chk("t_pcsel",  32'(bus.pc_sel_o), 32'(cs));
    chk("t_stall",  32'(bus.stall_o),  32'd0);
    chk("t_flush",  32'(bus.flush_o),  32'd0);
    chk_csr("t");

    if (kind == 0) begin
      if (we) begin
        if (a == 12'h300) begin m_mie = wd[3]; m_mpie = wd[7]; end
        else if (a == 12'h341) m_mepc = wd & 32'hFFFF_FFFC;
        else if (a == 12'h342) m_mcause = wd;
      end
      return;
    end

    if (kind == 1) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = cause;
    end
    for (int c = 1; c <= nb; c++) begin
      drive_junk(c < nb);
      chk("drain_stall", 32'(bus.stall_o), 32'd1);
      chk("drain_flush", 32'(bus.flush_o), 32'd0);
      chk("drain_kill",  32'(bus.kill_o),  32'd0);
      chk_csr("drain");
    end
    drive_junk(1'b0);
    chk("redir_pcsel", 32'(bus.pc_sel_o), (kind == 1) ? 32'd3 : 32'd2);
    chk("redir_flush", 32'(bus.flush_o),  32'd1);
    chk("redir_stall", 32'(bus.stall_o),  32'd1);
    chk("redir_kill",  32'(bus.kill_o),   32'd0);
    chk_csr("redir");
    if (kind == 1) begin m_mpie = m_mie; m_mie = 1'b0; end
    else           begin m_mie = m_mpie; m_mpie = 1'b1; end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    idle();
    chk("rst_pcsel", 32'(bus.pc_sel_o), 32'd0);
    chk("rst_kill",  32'(bus.kill_o),   32'd0);
    chk("rst_flush", 32'(bus.flush_o),  32'd0);
    chk("rst_stall", 32'(bus.stall_o),  32'd0);
    chk_csr("rst");
    rst = 1'b0;

    // ECALL at 0x100 with MIE set, memory idle
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h300, 32'h0000_0008);
    do_txn(I_ECALL, 1'b0, 32'h100, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    do_txn(I_NOP, 1'b0, 32'h4, 2'd1, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("ecall_mepc",   bus.mepc_o,          32'h100);
    chk("ecall_mcause", bus.mcause_o,        32'd11);
    chk("ecall_mie",    32'(bus.mie_o),      32'd0);
    chk("ecall_mpie",   32'(bus.mpie_o),     32'd1);

    // Illegal beats EBREAK
    do_txn(I_EBREAK, 1'b1, 32'h204, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    do_txn(I_NOP, 1'b0, 32'h8, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("ill_mcause", bus.mcause_o, 32'd2);
    chk("ill_mepc",   bus.mepc_o,   32'h204);

    // Drain of three busy cycles: stall through T+3, redirect at T+4
    do_txn(I_ECALL, 1'b0, 32'h3F0, 2'd1, 3, 1'b0, 1'b0, 12'h0, 32'h0);

    // Reset during DRAIN aborts the sequence
    drive(1'b1, I_ECALL, 1'b0, 32'h500, 2'd0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("abort_kill", 32'(bus.kill_o), 32'd1);
    drive_junk(1'b1);
    chk("abort_t1_stall", 32'(bus.stall_o), 32'd1);
    drive_junk(1'b1);
    rst = 1'b1;
    chk("abort_t2_stall", 32'(bus.stall_o), 32'd1);
    idle();
    model_reset();
    chk("abort_pcsel", 32'(bus.pc_sel_o), 32'd0);
    chk("abort_flush", 32'(bus.flush_o),  32'd0);
    chk("abort_stall", 32'(bus.stall_o),  32'd0);
    chk("abort_kill0", 32'(bus.kill_o),   32'd0);
    chk_csr("abort");
    rst = 1'b0;
    idle();
    chk("abort_t4_pcsel", 32'(bus.pc_sel_o), 32'd0);
    chk("abort_t4_flush", 32'(bus.flush_o),  32'd0);

    // MRET with mepc 0x300 and MPIE set
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h300, 32'h0000_0080);
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h341, 32'h0000_0300);
    do_txn(I_MRET, 1'b0, 32'h60, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    do_txn(I_NOP, 1'b0, 32'h300, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("mret_mie",  32'(bus.mie_o),  32'd1);
    chk("mret_mpie", 32'(bus.mpie_o), 32'd1);
    chk("mret_mepc", bus.mepc_o,      32'h300);

    // Interrupt with MIE set at pc 0x40, then with MIE clear
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h300, 32'h0000_0008);
    do_txn(I_NOP, 1'b0, 32'h40, 2'd1, 0, 1'b1, 1'b0, 12'h0, 32'h0);
    do_txn(I_NOP, 1'b0, 32'h44, 2'd1, 0, 1'b0, 1'b0, 12'h0, 32'h0);
`ifdef RISCV_TRAP_IRQ_EN
    chk("irq_mcause", bus.mcause_o, 32'h8000_000B);
    chk("irq_mepc",   bus.mepc_o,   32'h40);
`else
    chk("noirq_mcause", bus.mcause_o, 32'h0);
    chk("noirq_mepc",   bus.mepc_o,   32'h300);
`endif
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h300, 32'h0);
    do_txn(I_NOP, 1'b0, 32'h40, 2'd1, 0, 1'b1, 1'b0, 12'h0, 32'h0);

    // CSR mepc write alone, then colliding with an ECALL
    do_txn(I_NOP, 1'b0, 32'h0, 2'd0, 0, 1'b0, 1'b1, 12'h341, 32'h0000_0123);
    do_txn(I_NOP, 1'b0, 32'h4, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("csr_mepc", bus.mepc_o, 32'h120);
    do_txn(I_ECALL, 1'b0, 32'h80, 2'd0, 0, 1'b0, 1'b1, 12'h341, 32'h0000_0123);
    do_txn(I_NOP, 1'b0, 32'h4, 2'd0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    chk("collide_mepc", bus.mepc_o, 32'h80);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      do_txn(pick_instr($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), $urandom,
             2'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             pick_addr($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
